// File: rtl/eu_pkg.sv
// Shared types and constants for the execution-unit sequencer.
package eu_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 5;
    localparam int OP_W      = 4;
    localparam int FLAG_W    = 4;
    localparam int MEM_DEPTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        EXEC,
        WR,
        DONE
    } eu_state_t;

endpackage

// File: rtl/eu_wait_counter.sv
// Loadable down-counter; tc is high while the count sits at zero.
module eu_wait_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/eu_sequencer.sv
// Multi-cycle controller: read A, read B, execute, write back over one
// shared single-port memory so only one access occupies the port per cycle.
module eu_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5,
    parameter int OP_W   = 4,
    parameter int FLAG_W = 4,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OP_W-1:0]   opcode,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [ADDR_W-1:0] addr3,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [FLAG_W-1:0] flag,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rw,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [OP_W-1:0]   alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [FLAG_W-1:0] alu_flag
);
    import eu_pkg::*;

    // Counter loaded with RD_LAT gives RD_LAT+1 cycles of stable address.
    localparam logic [2:0] WAIT_INIT = 3'(RD_LAT);

    eu_state_t         state;
    logic [ADDR_W-1:0] addr1_q;
    logic [ADDR_W-1:0] addr2_q;
    logic [ADDR_W-1:0] addr3_q;
    logic              mem_rw_q;
    logic              wait_load;
    logic              wait_tc;
    logic              same_src;

    assign same_src  = (addr1_q == addr2_q);
    assign wait_load = ((state == IDLE) && start) ||
                       ((state == RD_A) && wait_tc && !same_src);

    eu_wait_counter #(.CNT_W(3)) u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (wait_load),
        .load_val (WAIT_INIT),
        .tc       (wait_tc)
    );

    // Write enable is cut the moment reset rises, even mid-WR.
    assign mem_rw  = mem_rw_q & ~rst;
    assign mem_din = result;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_rw_q   <= 1'b0;
            mem_addr   <= '0;
            result     <= '0;
            flag       <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            addr1_q    <= '0;
            addr2_q    <= '0;
            addr3_q    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RD_A;
                        busy       <= 1'b1;
                        alu_opcode <= opcode;
                        addr1_q    <= addr1;
                        addr2_q    <= addr2;
                        addr3_q    <= addr3;
                        mem_addr   <= addr1;
                    end
                end
                RD_A: begin
                    if (wait_tc) begin
                        alu_a <= mem_dout;
                        if (same_src) begin
                            alu_b    <= mem_dout;
                            state    <= EXEC;
                            mem_addr <= '0;
                        end else begin
                            state    <= RD_B;
                            mem_addr <= addr2_q;
                        end
                    end
                end
                RD_B: begin
                    if (wait_tc) begin
                        alu_b    <= mem_dout;
                        state    <= EXEC;
                        mem_addr <= '0;
                    end
                end
                EXEC: begin
                    result   <= alu_out;
                    flag     <= alu_flag;
                    state    <= WR;
                    mem_addr <= addr3_q;
                    mem_rw_q <= 1'b1;
                end
                WR: begin
                    state    <= DONE;
                    mem_addr <= '0;
                    mem_rw_q <= 1'b0;
                    done     <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eu_sequencer.sv
// Bench for eu_sequencer: memory/ALU models, vector table, scoreboard on done.
module tb_eu_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, start3;
    logic [3:0] opcode;
    logic [4:0] addr1, addr2, addr3;

    logic       busy, done, mem_rw;
    logic [7:0] result, mem_din, mem_dout, alu_a, alu_b, alu_out;
    logic [3:0] flag, alu_opcode, alu_flag;
    logic [4:0] mem_addr;

    logic       busy3, done3, mem_rw3;
    logic [7:0] result3, mem_din3, mem_dout3, alu_a3, alu_b3, alu_out3;
    logic [3:0] flag3, alu_opcode3, alu_flag3;
    logic [4:0] mem_addr3;

    eu_sequencer #(.RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode),
        .addr1(addr1), .addr2(addr2), .addr3(addr3),
        .busy(busy), .done(done), .result(result), .flag(flag),
        .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_din(mem_din), .mem_dout(mem_dout),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_flag(alu_flag)
    );

    eu_sequencer #(.RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .opcode(opcode),
        .addr1(addr1), .addr2(addr2), .addr3(addr3),
        .busy(busy3), .done(done3), .result(result3), .flag(flag3),
        .mem_addr(mem_addr3), .mem_rw(mem_rw3), .mem_din(mem_din3), .mem_dout(mem_dout3),
        .alu_opcode(alu_opcode3), .alu_a(alu_a3), .alu_b(alu_b3),
        .alu_out(alu_out3), .alu_flag(alu_flag3)
    );

    // ALU model: flag = {0, neg, carry/borrow, zero}
    function automatic logic [11:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] w;
        logic       c;
        c = 1'b0;
        case (op)
            4'h0: begin w = {1'b0, a} + {1'b0, b}; c = w[8]; end
            4'h1: begin w = {1'b0, a} - {1'b0, b}; c = (a < b); end
            4'h2: w = {1'b0, a & b};
            4'h4: w = {1'b0, a ^ b};
            default: w = {1'b0, a};
        endcase
        return {1'b0, w[7], c, (w[7:0] == 8'h00), w[7:0]};
    endfunction

    assign {alu_flag, alu_out}   = alu_f(alu_opcode, alu_a, alu_b);
    assign {alu_flag3, alu_out3} = alu_f(alu_opcode3, alu_a3, alu_b3);

    // Synchronous memories: RD_LAT=1 for dut, RD_LAT=3 for dut3
    logic [7:0] mem  [32];
    logic [7:0] mem3 [32];
    logic [7:0] rd1;
    logic [7:0] p3 [3];
    logic       ld_en;
    logic [4:0] ld_addr;
    logic [7:0] ld_data;

    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr]  <= ld_data;
            mem3[ld_addr] <= ld_data;
        end else begin
            if (mem_rw)  mem[mem_addr]   <= mem_din;
            if (mem_rw3) mem3[mem_addr3] <= mem_din3;
        end
        rd1   <= mem[mem_addr];
        p3[0] <= mem3[mem_addr3];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign mem_dout  = rd1;
    assign mem_dout3 = p3[2];

    typedef struct {
        logic [3:0] op;
        logic [4:0] a1;
        logic [4:0] a2;
        logic [4:0] a3;
        int         done_cyc;
        int         wr_cyc;
        logic [7:0] res;
        logic [3:0] flg;
    } vec_t;

    typedef struct {
        logic [4:0] a3;
        logic [7:0] res;
        logic [3:0] flg;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    endtask

    task automatic poke(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    // Scoreboard: every done pops one expectation pushed at start.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_result", result, mon_e.res);
                chk("sb_flag", flag, mon_e.flg);
                chk("sb_mem_dest", mem[mon_e.a3], mon_e.res);
            end
        end
    end

    task automatic run_op(input vec_t v, input int idx);
        int   dcyc, wcyc, wcnt, aend;
        exp_t e;
        @(negedge clk);
        opcode = v.op; addr1 = v.a1; addr2 = v.a2; addr3 = v.a3; start = 1'b1;
        e.a3 = v.a3; e.res = v.res; e.flg = v.flg;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        dcyc = -1; wcyc = -1; wcnt = 0; aend = -1;
        for (int k = 1; k <= 30 && dcyc < 0; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 2) begin
                opcode = 4'($urandom); addr1 = 5'($urandom);
                addr2 = 5'($urandom);  addr3 = 5'($urandom);
            end
            if (mem_rw) begin wcnt++; wcyc = k; end
            if (done) begin dcyc = k; aend = int'(mem_addr); end
        end
        chk($sformatf("done_cycle[%0d]", idx), dcyc, v.done_cyc);
        chk($sformatf("wr_cycle[%0d]", idx), wcyc, v.wr_cyc);
        chk($sformatf("wr_count[%0d]", idx), wcnt, 1);
        chk($sformatf("addr_in_done[%0d]", idx), aend, 0);
        @(negedge clk);
        chk($sformatf("idle_after[%0d]", idx), busy, 0);
    endtask

    vec_t vecs[9];

    initial begin
        int ndone, ca, cb, d3, w3;

        vecs[0] = '{4'h0, 5'd3,  5'd7,  5'd9,  7, 6, 8'h46, 4'h0};
        vecs[1] = '{4'h0, 5'd5,  5'd5,  5'd6,  5, 4, 8'h42, 4'h0};
        vecs[2] = '{4'h0, 5'd9,  5'd3,  5'd9,  7, 6, 8'h58, 4'h0};
        vecs[3] = '{4'h1, 5'd7,  5'd3,  5'd10, 7, 6, 8'h22, 4'h0};
        vecs[4] = '{4'h1, 5'd3,  5'd7,  5'd11, 7, 6, 8'hDE, 4'h6};
        vecs[5] = '{4'h0, 5'd9,  5'd9,  5'd12, 5, 4, 8'hB0, 4'h4};
        vecs[6] = '{4'h0, 5'd11, 5'd6,  5'd13, 7, 6, 8'h20, 4'h2};
        vecs[7] = '{4'h2, 5'd3,  5'd10, 5'd14, 7, 6, 8'h02, 4'h0};
        vecs[8] = '{4'h4, 5'd9,  5'd9,  5'd15, 5, 4, 8'h00, 4'h1};

        rst = 1'b1; start = 1'b0; start3 = 1'b0; ld_en = 1'b0;
        ld_addr = '0; ld_data = '0; opcode = '0; addr1 = '0; addr2 = '0; addr3 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_rw", mem_rw, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_result", result, 0);
        chk("rst_flag", flag, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_opcode", alu_opcode, 0);
        chk("rst_busy3", busy3, 0);
        rst = 1'b0;

        poke(5'd3, 8'h12);
        poke(5'd7, 8'h34);
        poke(5'd5, 8'h21);
        poke(5'd16, 8'hAA);
        poke(5'd17, 8'h5C);

        for (int i = 0; i < 9; i++) run_op(vecs[i], i);

        // start pulsed in cycles 2 and 7 of a running op must be ignored
        @(negedge clk);
        opcode = 4'h0; addr1 = 5'd3; addr2 = 5'd7; addr3 = 5'd17; start = 1'b1;
        mon_e.a3 = 5'd17; mon_e.res = 8'h46; mon_e.flg = 4'h0;
        sb.push_back(mon_e);
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 14; k++) begin
            if (k > 1) @(negedge clk);
            if (k == 2 || k == 7) begin
                start = 1'b1; opcode = 4'h1; addr1 = 5'd5; addr2 = 5'd6; addr3 = 5'd3;
            end else begin
                start = 1'b0;
            end
            if (done) ndone++;
            if (k == 8) chk("ignored_start_idle", busy, 0);
        end
        chk("ignored_start_dones", ndone, 1);
        chk("ignored_start_mem3", mem[3], 8'h12);

        // reset during WR: no write, state cleared, no done
        @(negedge clk);
        opcode = 4'h0; addr1 = 5'd3; addr2 = 5'd7; addr3 = 5'd16; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
        end
        chk("wr_rw_before_rst", mem_rw, 1);
        rst = 1'b1;
        #1 chk("wr_rw_during_rst", mem_rw, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", done, 0);
        chk("post_rst_result", result, 0);
        chk("post_rst_flag", flag, 0);
        chk("post_rst_alu_a", alu_a, 0);
        chk("post_rst_dest", mem[16], 8'hAA);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("post_rst_no_done", ndone, 0);

        // RD_LAT = 3 instance
        poke(5'd2, 8'h10);
        poke(5'd4, 8'h05);
        @(negedge clk);
        opcode = 4'h0; addr1 = 5'd2; addr2 = 5'd4; addr3 = 5'd8; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        ca = 0; cb = 0; d3 = -1; w3 = -1;
        for (int k = 1; k <= 30 && d3 < 0; k++) begin
            if (k > 1) @(negedge clk);
            if (mem_addr3 == 5'd2 && !mem_rw3) ca++;
            if (mem_addr3 == 5'd4 && !mem_rw3) cb++;
            if (mem_rw3) w3 = k;
            if (done3) d3 = k;
        end
        chk("lat3_hold_a", ca, 4);
        chk("lat3_hold_b", cb, 4);
        chk("lat3_wr_cycle", w3, 10);
        chk("lat3_done_cycle", d3, 11);
        chk("lat3_result", result3, 8'h15);
        chk("lat3_mem_dest", mem3[8], 8'h15);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/eu_sequencer.md
Name: eu_sequencer

Overview:
- Multi-cycle controller for the execution unit's shared single-port 32x8 memory and 4-bit-opcode ALU.
- Accepts one instruction (opcode, two source addresses, one destination address) and reads operand A, then operand B, over the single port.
- Then executes on the ALU and writes the result back, so the port is never driven by more than one access per cycle.
- Sits between the instruction source and the memory/ALU instances inside the EU.

Parameters:
- DATA_W, 8, operand/result width.
- ADDR_W, 5, memory address width (32 words).
- OP_W, 4, ALU opcode width.
- FLAG_W, 4, ALU flag width.
- RD_LAT, 1, memory read latency in cycles, legal range 1..4.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  request to execute one instruction; accepted only in IDLE.
- opcode  in  OP_W  ALU operation, latched on accept.
- addr1  in  ADDR_W  source A address, latched on accept.
- addr2  in  ADDR_W  source B address, latched on accept.
- addr3  in  ADDR_W  destination address, latched on accept.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: instruction complete, memory written.
- result  out  DATA_W  last ALU result (registered).
- flag  out  FLAG_W  last ALU flags (registered).
- mem_addr  out  ADDR_W  memory address.
- mem_rw  out  1  0 = read, 1 = write.
- mem_din  out  DATA_W  write data to memory (always equals result).
- mem_dout  in  DATA_W  read data from memory.
- alu_opcode  out  OP_W  latched opcode.
- alu_a  out  DATA_W  operand A register.
- alu_b  out  DATA_W  operand B register.
- alu_out  in  DATA_W  ALU result.
- alu_flag  in  FLAG_W  ALU flags.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state = IDLE. busy, done, mem_rw = 0. mem_addr, result, flag, alu_a, alu_b, alu_opcode and all latched addresses = 0.
- mem_rw is combinationally gated with !rst, so no write is ever issued in a cycle where rst = 1. This holds even if rst arrives while in WR.
- States: IDLE, RD_A, RD_B, EXEC, WR, DONE.
- IDLE -> RD_A: start = 1 at a clock edge latches opcode and addr1/2/3.
- RD_A:
  - mem_addr = addr1_q, mem_rw = 0, held stable for RD_LAT+1 cycles; a 3-bit wait counter counts them.
  - alu_a captures mem_dout on the edge ending the last cycle.
  - If addr1_q == addr2_q, alu_b captures the same data and the next state is EXEC; otherwise the next state is RD_B.
- RD_B: same as RD_A with addr2_q, capturing alu_b; next state EXEC.
- EXEC: one cycle. The ALU sees alu_opcode/alu_a/alu_b; result and flag capture alu_out and alu_flag at the end of the cycle.
- WR: one cycle with mem_addr = addr3_q, mem_rw = 1, mem_din = result.
- DONE: done = 1 for exactly one cycle, then IDLE.
- Latency (RD_LAT = 1, addr1 != addr2), with start accepted at edge 0:
  - RD_A cycles 1–2, RD_B 3–4, EXEC 5, WR 6, DONE 7.
  - done high in cycle 7; the next start is acceptable at the edge ending cycle 8.
  - General: done cycle = 2*(RD_LAT+1)+3. With addr1 == addr2 it is RD_LAT+1 fewer.
- start while busy (including DONE): ignored; no queueing. Inputs may change freely while busy.
- mem_addr = 0 and mem_rw = 0 in IDLE, EXEC and DONE.
- addr3 equal to addr1 or addr2: legal. Operands are already captured before WR, so the old values are used.
- Reset mid-operation: state returns to IDLE at the edge. Any partially read operands are discarded (registers cleared), and done is not pulsed.

Decomposition:
- Package eu_pkg:
  - state enumeration (IDLE, RD_A, RD_B, EXEC, WR, DONE);
  - constants DATA_W = 8, ADDR_W = 5, OP_W = 4, FLAG_W = 4, MEM_DEPTH = 32.
- One sub-module, eu_wait_counter: loadable down-counter with a terminal-count output, used for the RD_A/RD_B hold time.

Test Plan:
- Bench uses a synchronous 32x8 memory model and an ALU model with out = a+b for opcode 4'h0.
- Add, RD_LAT = 1: mem[3] = 8'h12, mem[7] = 8'h34; start op = 0, a1 = 3, a2 = 7, a3 = 9 -> done in cycle 7; mem[9] = 8'h46; result = 8'h46; exactly one write cycle observed (cycle 6).
- Same source: mem[5] = 8'h21; a1 = a2 = 5, a3 = 6 -> RD_B skipped; done in cycle 5; mem[6] = 8'h42.
- In-place overwrite: a1 = 9, a2 = 3, a3 = 9 with mem[9] = 8'h46, mem[3] = 8'h12 -> mem[9] = 8'h58.
- start pulsed in cycles 2 and 7 of a running op -> both ignored; only one done; the second op starts only after IDLE is re-entered.
- rst asserted during WR -> mem_rw = 0 that cycle; destination unchanged; the next cycle has busy = 0, done never pulses, and result/flag = 0.
- RD_LAT = 3 -> mem_addr held 4 cycles per read; done in cycle 11.
